// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter driving an asynchronous SRAM through a registered tristate buffer
// Optional SRAM_ARB_ROUND_ROBIN_EN: round-robin between simultaneous requests instead of port-0 priority.
module sram_arbiter #(
    parameter int N           = 16,
    parameter int A           = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [A-1:0] addr0,
    input  logic [A-1:0] addr1,
    input  logic [N-1:0] wdata0,
    input  logic [N-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic         wdone0,
    output logic         wdone1,
    output logic [N-1:0] rdata,
    output logic         busy,
    output logic [A-1:0] SRAM_ADDR,
    output logic         SRAM_CE_N,
    output logic         SRAM_OE_N,
    output logic         SRAM_WE_N,
    output logic         SRAM_UB_N,
    output logic         SRAM_LB_N,
    output logic         tristate_output_enable,
    output logic [N-1:0] Data_to_SRAM,
    input  logic [N-1:0] Data_from_SRAM
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, CAPTURE, DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t         state;
    state_t         state_next;
    logic [3:0]     wait_cnt;
    logic           we_q;
    logic           port_q;
    logic [A-1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic [N-1:0]   rdata_q;
    logic           sel1;
    logic           take;
    logic           sel_we;
    logic [A-1:0]   sel_addr;
    logic [N-1:0]   sel_wdata;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // rr_ptr set means port 1 holds priority for the next simultaneous request
    logic rr_ptr;

    assign sel1 = req1 & (~req0 | rr_ptr);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= 1'b0;
        end else if (take) begin
            rr_ptr <= ~sel1;
        end
    end
`else
    assign sel1 = req1 & ~req0;
`endif

    assign take      = (state == IDLE) & (req0 | req1);
    assign sel_we    = sel1 ? we1    : we0;
    assign sel_addr  = sel1 ? addr1  : addr0;
    assign sel_wdata = sel1 ? wdata1 : wdata0;

    // Write data is only captured for writes so the bus value holds across reads
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            we_q     <= 1'b0;
            port_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                we_q   <= sel_we;
                port_q <= sel1;
                addr_q <= sel_addr;
                if (sel_we) begin
                    wdata_q <= sel_wdata;
                end
            end
            if (state == SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == CAPTURE) begin
                rdata_q <= Data_from_SRAM;
            end
        end
    end

    always_comb begin
        state_next             = state;
        gnt0                   = 1'b0;
        gnt1                   = 1'b0;
        rvalid0                = 1'b0;
        rvalid1                = 1'b0;
        wdone0                 = 1'b0;
        wdone1                 = 1'b0;
        SRAM_CE_N              = 1'b1;
        SRAM_OE_N              = 1'b1;
        SRAM_WE_N              = 1'b1;
        SRAM_UB_N              = 1'b1;
        SRAM_LB_N              = 1'b1;
        tristate_output_enable = 1'b0;
        busy                   = (state != IDLE);
        case (state)
            IDLE: begin
                if (take) begin
                    gnt0       = ~sel1;
                    gnt1       = sel1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                SRAM_CE_N              = 1'b0;
                SRAM_UB_N              = 1'b0;
                SRAM_LB_N              = 1'b0;
                tristate_output_enable = we_q;
                state_next             = ACCESS;
            end
            ACCESS: begin
                SRAM_CE_N              = 1'b0;
                SRAM_UB_N              = 1'b0;
                SRAM_LB_N              = 1'b0;
                SRAM_WE_N              = ~we_q;
                SRAM_OE_N              = we_q;
                tristate_output_enable = we_q;
                if (wait_cnt <= 4'd1) begin
                    state_next = we_q ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                SRAM_CE_N  = 1'b0;
                state_next = DONE;
            end
            DONE: begin
                rvalid0                = ~we_q & ~port_q;
                rvalid1                = ~we_q &  port_q;
                wdone0                 =  we_q & ~port_q;
                wdone1                 =  we_q &  port_q;
                tristate_output_enable = we_q;
                state_next             = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign SRAM_ADDR    = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign rdata        = rdata_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter N, default 16, SRAM data width in bits.
REQ-002 Parameter A, default 20, SRAM address width in bits.
REQ-003 Parameter WAIT_CYCLES, default 1, range 1..15, number of ACCESS cycles per transfer.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low: Clk input 1 system clock (all flops on rising edge); Reset_n input 1 asynchronous active-low reset.
REQ-005 req0, req1 input 1 each; access request, held high by requester until its gnt pulse.
REQ-006 we0, we1 input 1 each; 1 = write, 0 = read, valid while req high.
REQ-007 addr0, addr1 input A each; word address.
REQ-008 wdata0, wdata1 input N each; write data.
REQ-009 gnt0, gnt1 output 1 each; one-cycle pulse, request accepted and inputs latched.
REQ-010 rvalid0, rvalid1 output 1 each; one-cycle pulse, rdata valid for that port.
REQ-011 wdone0, wdone1 output 1 each; one-cycle pulse, write complete.
REQ-012 rdata output N; read data, shared by both ports.
REQ-013 busy output 1; high in every state except IDLE.
REQ-014 SRAM_ADDR output A; SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N output 1 each; active-low SRAM strobes.
REQ-015 tristate_output_enable output 1; Data_to_SRAM output N; Data_from_SRAM input N; connect to the registered tristate bus buffer (write path and read path each one flop deep).

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, CAPTURE, DONE.
REQ-017 IDLE: if any req is high, pulse the selected gnt, latch that port's we/addr/wdata/port-id, and go to SETUP; otherwise stay in IDLE.
REQ-018 SETUP (1 cycle): SRAM_ADDR = latched addr, CE_N=0, UB_N=0, LB_N=0; on a write, Data_to_SRAM = wdata and tristate_output_enable=1 (this preloads the tristate write register), WE_N=1; go to ACCESS.
REQ-019 ACCESS (WAIT_CYCLES cycles, 4-bit down-counter): keep the SETUP signals; a read drives OE_N=0, a write drives WE_N=0 and keeps tristate_output_enable=1; on the last cycle a read goes to CAPTURE and a write goes to DONE.
REQ-020 CAPTURE (read only, 1 cycle): CE_N=0, OE_N=1; rdata <= Data_from_SRAM at the end of the cycle; go to DONE.
REQ-021 DONE (1 cycle): pulse rvalid or wdone for the latched port; a write keeps tristate_output_enable=1 and WE_N=1 for bus hold; go to IDLE.
REQ-022 Latency with WAIT_CYCLES=1, grant in cycle T: read rvalid in T+4, write wdone in T+3; next grant no earlier than the IDLE cycle after DONE.
REQ-023 SRAM_WE_N and SRAM_OE_N SHALL never be low in the same cycle; tristate_output_enable SHALL be 0 whenever OE_N=0.
REQ-024 Requests arriving while busy are ignored until IDLE; they are not queued and requires no extra state.
REQ-025 Outside the states above, all strobes are high, tristate_output_enable=0, SRAM_ADDR and Data_to_SRAM hold their last value, and rdata holds until the next CAPTURE.

Reset
REQ-026 Reset_n=0 SHALL immediately force IDLE; all SRAM_*_N=1; tristate_output_enable=0; SRAM_ADDR, Data_to_SRAM, rdata = 0; all gnt/rvalid/wdone=0; busy=0; counter=0; round-robin pointer = port 0 priority.
REQ-027 A reset mid-transfer aborts the transfer without any rvalid or wdone pulse; after Reset_n deasserts, the first grant occurs in the first IDLE cycle with a req high.

Configuration
REQ-028 Macro SRAM_ARB_ROUND_ROBIN_EN defined: when both requests are simultaneous, grant the port not granted most recently (the pointer updates on each gnt; after reset port 0 wins).
REQ-029 Macro undefined: fixed priority, port 0 always wins simultaneous requests, and no pointer flop is built.

Verification
REQ-030 Reset mid-ACCESS of a write -> next cycle WE_N=1, CE_N=1, tristate_output_enable=0, no wdone.
REQ-031 req0 write addr 0x00010 data 0xBEEF, then read of the same address -> wdone0 at T+3; rvalid0 at T+4 of the read with rdata=0xBEEF.
REQ-032 req0 and req1 high continuously, reads -> with the macro, grants alternate 0,1,0,1; without it, gnt0 only.
REQ-033 WAIT_CYCLES=3 read -> OE_N low for exactly 3 cycles; rvalid at T+6.
REQ-034 Every cycle of all tests -> assert WE_N and OE_N are never both low, and OE_N=0 implies tristate_output_enable=0.
